// File: rtl/rr_arbiter_4.sv
// -----------------------------------------------------------------------------
// rr_arbiter_4
//
// Four-requester round-robin arbiter for one shared downstream select path.
// The owner keeps the grant for as long as it holds its request, but no
// longer than MAX_HOLD consecutive cycles. Every release, whether voluntary
// or forced, is followed by at least one idle cycle. After a release the
// previous owner becomes the lowest-priority requester.
//
// Parameters
//   MAX_HOLD  maximum consecutive grant cycles per ownership (1..255)
//
// Ports
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset
//   req      in   [3:0] level-sensitive request, one bit per master
//   gnt      out  [3:0] registered one-hot grant, 0000 when there is no owner
//   gnt_idx  out  [1:0] index of the current (or most recent) owner
//   busy     out  high while any gnt bit is high
//   timeout  out  one-cycle pulse in the idle cycle after a forced release
// -----------------------------------------------------------------------------
module rr_arbiter_4 #(
   parameter int unsigned MAX_HOLD = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] req,
   output logic [3:0] gnt,
   output logic [1:0] gnt_idx,
   output logic       busy,
   output logic       timeout
);

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_e;

   // The hold counter is 8 bits wide, so MAX_HOLD is only meaningful up to 255.
   localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD);

   state_e     state_q,   state_d;
   logic [1:0] owner_q,   owner_d;
   logic [1:0] last_q,    last_d;
   logic [7:0] cnt_q,     cnt_d;
   logic [3:0] gnt_q,     gnt_d;
   logic       busy_q,    busy_d;
   logic       timeout_q, timeout_d;

   // Circular scan starting just after the last-served master. The final
   // probe (k=4) wraps back to `last` itself, so the previous owner can be
   // re-granted only when nobody else is requesting.
   function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
      logic [1:0] idx;
      logic [1:0] pick;
      logic       found;
      pick  = last;
      found = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         idx = last + 2'(k);
         if (!found && r[idx]) begin
            pick  = idx;
            found = 1'b1;
         end
      end
      return pick;
   endfunction

   function automatic logic [3:0] decode(input logic [1:0] idx);
      return 4'b0001 << idx;
   endfunction

   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      last_d    = last_q;
      cnt_d     = cnt_q;
      gnt_d     = gnt_q;
      busy_d    = busy_q;
      timeout_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (|req) begin
               owner_d = rr_pick(req, last_q);
               state_d = GRANT;
               gnt_d   = decode(owner_d);
               busy_d  = 1'b1;
               cnt_d   = 8'd1;
            end
         end

         GRANT: begin
            // Voluntary release takes precedence over the hold limit, so a
            // master dropping its request on the last allowed cycle does not
            // raise timeout.
            if (!req[owner_q]) begin
               state_d = IDLE;
               gnt_d   = 4'b0000;
               busy_d  = 1'b0;
               last_d  = owner_q;
            end else if (cnt_q == HOLD_LIM) begin
               state_d   = IDLE;
               gnt_d     = 4'b0000;
               busy_d    = 1'b0;
               last_d    = owner_q;
               timeout_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end

         default: begin
            state_d = IDLE;
            gnt_d   = 4'b0000;
            busy_d  = 1'b0;
         end
      endcase
   end

   // last resets to 3 so the first grant after reset favours master 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         owner_q   <= 2'd0;
         last_q    <= 2'd3;
         cnt_q     <= 8'd0;
         gnt_q     <= 4'b0000;
         busy_q    <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         last_q    <= last_d;
         cnt_q     <= cnt_d;
         gnt_q     <= gnt_d;
         busy_q    <= busy_d;
         timeout_q <= timeout_d;
      end
   end

   assign gnt     = gnt_q;
   assign gnt_idx = owner_q;
   assign busy    = busy_q;
   assign timeout = timeout_q;

endmodule

// File: tb/tb_rr_arbiter_4.sv
module tb_rr_arbiter_4;

   logic       clk;
   logic       rst_n;
   logic [3:0] req;

   logic [3:0] gnt8, gnt1;
   logic [1:0] idx8, idx1;
   logic       busy8, busy1;
   logic       to8, to1;

   int total = 0;
   int bad   = 0;

   // Reference state per instance: [0] is MAX_HOLD=8, [1] is MAX_HOLD=1.
   int m_hold [2] = '{8, 1};
   bit m_busy [2];
   int m_own  [2];
   int m_last [2];
   int m_cnt  [2];
   bit m_to   [2];

   rr_arbiter_4 #(.MAX_HOLD(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .req(req),
      .gnt(gnt8), .gnt_idx(idx8), .busy(busy8), .timeout(to8)
   );

   rr_arbiter_4 #(.MAX_HOLD(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .req(req),
      .gnt(gnt1), .gnt_idx(idx1), .busy(busy1), .timeout(to1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_busy[i] = 1'b0;
         m_own[i]  = 0;
         m_last[i] = 3;
         m_cnt[i]  = 0;
         m_to[i]   = 1'b0;
      end
   endtask

   // One clock edge of the arbitration rules, applied to the sampled req.
   task automatic model_step(input int i, input logic [3:0] r);
      m_to[i] = 1'b0;
      if (!m_busy[i]) begin
         if (r != 4'b0000) begin
            for (int k = 1; k <= 4; k++) begin
               int c;
               c = (m_last[i] + k) % 4;
               if (r[c]) begin
                  m_own[i]  = c;
                  m_busy[i] = 1'b1;
                  m_cnt[i]  = 1;
                  break;
               end
            end
         end
      end else if (!r[m_own[i]]) begin
         m_busy[i] = 1'b0;
         m_last[i] = m_own[i];
      end else if (m_cnt[i] == m_hold[i]) begin
         m_busy[i] = 1'b0;
         m_last[i] = m_own[i];
         m_to[i]   = 1'b1;
      end else begin
         m_cnt[i] = m_cnt[i] + 1;
      end
   endtask

   task automatic check_model(input string tag);
      logic [3:0] eg8, eg1;
      eg8 = m_busy[0] ? (4'b0001 << m_own[0]) : 4'b0000;
      eg1 = m_busy[1] ? (4'b0001 << m_own[1]) : 4'b0000;
      check({tag, ".h8.gnt"},  32'(gnt8),  32'(eg8));
      check({tag, ".h8.idx"},  32'(idx8),  32'(m_own[0]));
      check({tag, ".h8.busy"}, 32'(busy8), 32'(m_busy[0]));
      check({tag, ".h8.to"},   32'(to8),   32'(m_to[0]));
      check({tag, ".h1.gnt"},  32'(gnt1),  32'(eg1));
      check({tag, ".h1.idx"},  32'(idx1),  32'(m_own[1]));
      check({tag, ".h1.busy"}, 32'(busy1), 32'(m_busy[1]));
      check({tag, ".h1.to"},   32'(to1),   32'(m_to[1]));
   endtask

   // Advance one edge: update the model with the req being sampled, then
   // look at the outputs 1 time unit after the edge.
   task automatic tick(input string tag);
      if (rst_n) begin
         model_step(0, req);
         model_step(1, req);
      end
      @(posedge clk);
      #1;
      check_model(tag);
   endtask

   initial begin
      rst_n = 1'b0;
      req   = 4'b1111;
      model_reset();

      // Reset held with all masters requesting.
      repeat (3) tick("rst");
      #2 rst_n = 1'b1;

      // Saturation with MAX_HOLD=8: 8 grant cycles then one timeout cycle each.
      for (int c = 0; c < 45; c++) begin
         int slot, m;
         tick("sat");
         slot = c % 9;
         m    = (c / 9) % 4;
         check("sat.gnt", 32'(gnt8), (slot < 8) ? (32'd1 << m) : 32'd0);
         check("sat.to",  32'(to8),  (slot == 8) ? 32'd1 : 32'd0);
      end

      // Voluntary release by master 2.
      req = 4'b0000;
      repeat (2) tick("drain");
      req = 4'b0100;
      repeat (3) begin
         tick("vol");
         check("vol.gnt", 32'(gnt8), 32'h4);
         check("vol.idx", 32'(idx8), 32'h2);
         check("vol.to",  32'(to8),  32'h0);
      end
      req = 4'b0000;
      tick("vol.rel");
      check("vol.rel.gnt", 32'(gnt8), 32'h0);
      check("vol.rel.to",  32'(to8),  32'h0);

      // Rotation: master 3 is next after 2, then master 0.
      req = 4'b1001;
      tick("rot");
      check("rot.first", 32'(gnt8), 32'h8);
      repeat (2) tick("rot.hold");
      req = 4'b0001;
      tick("rot.rel");
      check("rot.rel.gnt", 32'(gnt8), 32'h0);
      tick("rot.next");
      check("rot.second", 32'(gnt8), 32'h1);
      req = 4'b0000;
      repeat (2) tick("drain");

      // MAX_HOLD=1 alternation from a fresh reset.
      #1 rst_n = 1'b0;
      model_reset();
      #2 rst_n = 1'b1;
      req = 4'b0011;
      for (int c = 0; c < 8; c++) begin
         tick("mh1");
         check("mh1.gnt", 32'(gnt1), (c % 4 == 0) ? 32'h1 : (c % 4 == 2) ? 32'h2 : 32'h0);
         check("mh1.to",  32'(to1),  (c % 2 == 1) ? 32'h1 : 32'h0);
      end

      // Randomized traffic with occasional mid-cycle resets.
      for (int c = 0; c < 400; c++) begin
         if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 99) == 0) begin
            rst_n = 1'b0;
            model_reset();
            #1 check_model("rnd.arst");
            #1 rst_n = 1'b1;
         end
         tick("rnd");
      end

      // Async reset mid-grant.
      req = 4'b0000;
      repeat (3) tick("drain");
      req = 4'b0100;
      tick("arst.pre");
      check("arst.pre.gnt", 32'(gnt8), 32'h4);
      rst_n = 1'b0;
      model_reset();
      #1;
      check("arst.gnt",  32'(gnt8),  32'h0);
      check("arst.busy", 32'(busy8), 32'h0);
      check("arst.idx",  32'(idx8),  32'h0);
      check_model("arst");
      req = 4'b1111;
      #2 rst_n = 1'b1;
      tick("arst.post");
      check("arst.post.gnt8", 32'(gnt8), 32'h1);
      check("arst.post.gnt1", 32'(gnt1), 32'h1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/rr_arbiter_4.md
# rr_arbiter_4

Four-requester round-robin arbiter that shares a single downstream resource (one of the four select lines of a 2-to-4 decoded target) between four masters. It holds a grant while the owning requester keeps its request asserted, forcibly releases it after a programmable hold limit, and presents the grant both as a 2-bit index and as its decoded one-hot form. It sits between the requesters and the decoded select path, and is the only block that drives that path.

## Interface

- MAX_HOLD, default 8: maximum consecutive grant cycles per ownership; legal range 1..255.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  4  request per master; level-sensitive, held by the master while it needs the resource.
- gnt  output  4  one-hot grant, registered; all-zero when no owner.
- gnt_idx  output  2  binary index of current owner; gnt is its 2-to-4 decode when busy=1.
- busy  output  1  high while any gnt bit is high.
- timeout  output  1  one-cycle pulse: the ownership that just ended was forcibly released at MAX_HOLD.

## Operation

- State: IDLE / GRANT; owner index (2b); last-served pointer `last` (2b); hold counter (8b).
- Reset (async, immediate on rst_n low): IDLE, gnt=0000, gnt_idx=00, busy=0, timeout=0, last=3, counter=0.
- IDLE: at a clock edge with req≠0, select the first set req bit scanning circularly from last+1 (last+1, last+2, last+3, last). Go to GRANT, gnt=decode(owner), gnt_idx=owner, busy=1, counter=1. With req=0000: stay in IDLE.
- GRANT, each edge, evaluated in this priority order:
  - req[owner]=0: normal release. Go to IDLE, gnt=0000, busy=0, last=owner, timeout=0.
  - req[owner]=1 and counter==MAX_HOLD: forced release. Go to IDLE, gnt=0000, busy=0, last=owner, timeout=1 for that one cycle.
  - Otherwise: hold; counter+1.
- gnt_idx keeps the last owner value while in IDLE. Only the gnt bits and busy indicate ownership.
- While in GRANT, req bits of non-owners are ignored. No preemption.
- timeout is 0 in every cycle except the single IDLE cycle that follows a forced release.
- Priority after any release: the previous owner becomes lowest priority. Starvation-free: a continuously requesting master waits at most 3×(MAX_HOLD+1) cycles.

## Timing

- Grant latency: req sampled at edge N with state IDLE gives gnt valid after edge N. 1 cycle.
- Release latency: req[owner] seen low at edge N gives gnt=0000 after edge N.
- There is always at least one dead cycle (gnt=0000) between two ownerships, including back-to-back re-grants to the same master.
- Maximum ownership: gnt high for exactly MAX_HOLD cycles when req is held. With MAX_HOLD=1, grants are single-cycle.
- Fully saturated period: all four masters requesting continuously gives a period of 4×(MAX_HOLD+1) cycles.
- A req pulse that falls before being sampled in IDLE is never granted.
- Reset asserted mid-grant: gnt drops asynchronously. After deassertion, the first grant goes to the lowest-numbered requester (last=3).
- Outputs are registered only. There is no combinational path from req to gnt.

## Test plan

- Reset check: assert rst_n=0 with req=1111 → gnt=0000, gnt_idx=00, busy=0, timeout=0 throughout. Deassert rst_n → gnt=0001 one edge later.
- Saturation, MAX_HOLD=8, req=1111 held: gnt=0001 for 8 cycles, then 0000 for 1 cycle with timeout=1, then 0010 ×8, 0100 ×8, 1000 ×8, then back to 0001. Period 36 cycles.
- Voluntary release: req=0100 held 3 cycles from IDLE → gnt=0100, gnt_idx=10 for 3 cycles starting one edge after req rises. gnt=0000 one edge after req falls. timeout stays 0.
- Rotation fairness: after owner 2 releases, apply req=1001 → gnt=1000 first. On its release → gnt=0001.
- MAX_HOLD=1, req=0011 held → gnt alternates 0001, 0000, 0010, 0000, with timeout=1 in every dead cycle.
- Async reset mid-grant: while gnt=0100, pulse rst_n low between edges → gnt=0000 immediately. Then release reset with req=1111 → gnt=0001.
